// File: rtl/counter_bank_pkg.sv
// counter_bank_pkg: shared constants, count-mode enum and parameter checks for the counter bank
package counter_bank_pkg;

    localparam int MAX_NCH   = 16;
    localparam int MIN_WIDTH = 8;
    localparam int MAX_WIDTH = 256;

    localparam int DEF_NCH   = 3;
    localparam int DEF_WIDTH = 121;
    localparam int DEF_HI    = 6;
    localparam int DEF_LO    = 8;
    localparam int DEF_SELW  = 2;
    localparam int TAPW      = DEF_HI + DEF_LO;

    typedef enum logic {WRAP = 1'b0, SAT = 1'b1} mode_e;

    function automatic bit params_ok(input int nch, input int width, input int hi, input int lo,
                                     input int selw);
        return nch >= 1 && nch <= MAX_NCH && width >= MIN_WIDTH && width <= MAX_WIDTH &&
               hi > 0 && lo > 0 && hi + lo <= width && (1 << selw) >= nch;
    endfunction

endpackage

// File: rtl/counter_bank_chan.sv
// counter_bank_chan: one counter channel with clear/load/count priority and terminal-count pulse
module counter_bank_chan
    import counter_bank_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             clr,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    input  logic             dir,
    input  logic             sat,
    output logic [WIDTH-1:0] cnt,
    output logic             tc
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    mode_e            mode;
    logic [WIDTH-1:0] stp;
    logic [WIDTH-1:0] nxt;
    logic             at_end;
    logic             stp_end;
    logic             tc_cnt;

    // Next count when enabled: saturating mode parks at the end value, wrapping mode flags leaving it
    always_comb begin
        mode    = mode_e'(sat);
        stp     = dir ? cnt + ONE : cnt - ONE;
        at_end  = dir ? &cnt : ~|cnt;
        stp_end = dir ? &stp : ~|stp;
        nxt     = (mode == SAT && at_end) ? cnt : stp;
        tc_cnt  = (mode == SAT) ? (!at_end && stp_end) : at_end;
    end

    // Count register: clear beats load beats count; tc only survives a counting edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
            tc  <= 1'b0;
        end else if (clr) begin
            cnt <= '0;
            tc  <= 1'b0;
        end else if (ld) begin
            cnt <= ld_val;
            tc  <= 1'b0;
        end else if (en) begin
            cnt <= nxt;
            tc  <= tc_cnt;
        end else begin
            tc  <= 1'b0;
        end
    end

endmodule

// File: rtl/counter_bank_ctl.sv
// counter_bank_ctl: bank of wide counters with hi/lo bit taps and a registered readback mux
module counter_bank_ctl
    import counter_bank_pkg::*;
#(
    parameter int NCH     = DEF_NCH,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int HI_BITS = DEF_HI,
    parameter int LO_BITS = DEF_LO,
    parameter int SELW    = DEF_SELW
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NCH-1:0]               en,
    input  logic [NCH-1:0]               clr,
    input  logic [NCH-1:0]               ld,
    input  logic [NCH*WIDTH-1:0]         ld_val,
    input  logic [NCH-1:0]               dir,
    input  logic [NCH-1:0]               sat,
    output logic [NCH-1:0]               tc,
    output logic [NCH*(HI_BITS+LO_BITS)-1:0] outx,
    input  logic                         rd_req,
    input  logic [SELW-1:0]              rd_sel,
    output logic                         rd_vld,
    output logic [WIDTH-1:0]             rd_data
);

    localparam int TW = HI_BITS + LO_BITS;

    if (!params_ok(NCH, WIDTH, HI_BITS, LO_BITS, SELW)) begin : g_bad_params
        $error("counter_bank_ctl: illegal parameter combination");
    end

    logic [WIDTH-1:0] cnt [NCH];
    logic [WIDTH-1:0] sel_cnt;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        counter_bank_chan #(.WIDTH(WIDTH)) u_chan (
            .clk    (clk),
            .reset_n(reset_n),
            .en     (en[c]),
            .clr    (clr[c]),
            .ld     (ld[c]),
            .ld_val (ld_val[c*WIDTH +: WIDTH]),
            .dir    (dir[c]),
            .sat    (sat[c]),
            .cnt    (cnt[c]),
            .tc     (tc[c])
        );
        assign outx[c*TW +: TW] = {cnt[c][WIDTH-1 -: HI_BITS], cnt[c][LO_BITS-1:0]};
    end

    // Readback mux; unpopulated select codes read as zero
    always_comb begin
        sel_cnt = '0;
        for (int i = 0; i < NCH; i++)
            if (rd_sel == SELW'(i)) sel_cnt = cnt[i];
    end

    // Readback register captures the pre-edge count; data holds between requests
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_vld  <= 1'b0;
            rd_data <= '0;
        end else begin
            rd_vld <= rd_req;
            if (rd_req) rd_data <= sel_cnt;
        end
    end

endmodule
